// File: rtl/frame_scanout.sv
// Raster scan-out for a 4-bit palette-index frame buffer with VGA timing; pins lag the counters by 2 clks.
// Optional page flipping at vblank when DOUBLE_BUFFER_EN is defined.
module frame_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int ADDR_W = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [3:0]        rdata,
    output logic [3:0]        pixel_idx,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              vblank_start,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_sel
);
    localparam int H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FB_PIXELS = H_VIS * V_VIS;
    localparam int HC_W      = $clog2(H_TOT);
    localparam int VC_W      = $clog2(V_TOT);
    localparam int AC_W      = $clog2(FB_PIXELS + 1);

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0] H_VIS_C  = HC_W'(H_VIS);
    localparam logic [HC_W-1:0] HS_BEG   = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0] V_VIS_C  = VC_W'(V_VIS);
    localparam logic [VC_W-1:0] V_VLAST  = VC_W'(V_VIS - 1);
    localparam logic [VC_W-1:0] VS_BEG   = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_VIS + V_FP + V_SYNC);

    logic [HC_W-1:0]   r_h_cnt;
    logic [VC_W-1:0]   r_v_cnt;
    logic [AC_W-1:0]   r_addr_cnt;
    logic              r_vis_b;
    logic              r_hs_b;
    logic              r_vs_b;

    logic              w_h_last;
    logic              w_v_last;
    logic              w_vis_a;
    logic              w_hs_a;
    logic              w_vs_a;
    logic              w_vb_edge;
    logic [ADDR_W-1:0] w_base;

    assign w_h_last  = (r_h_cnt == H_LAST);
    assign w_v_last  = (r_v_cnt == V_LAST);
    assign w_vis_a   = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
    assign w_hs_a    = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign w_vs_a    = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    assign w_vb_edge = w_h_last && (r_v_cnt == V_VLAST);
    assign w_base    = front_sel ? ADDR_W'(FB_PIXELS) : '0;

    // Stage A counters and address, stage B alignment, stage C pins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_addr_cnt   <= '0;
            r_addr       <= '0;
            r_vis_b      <= 1'b0;
            r_hs_b       <= 1'b1;
            r_vs_b       <= 1'b1;
            pixel_idx    <= '0;
            VGA_HS       <= 1'b1;
            VGA_VS       <= 1'b1;
            VGA_BLANK_N  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + HC_W'(1);
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
            end
            if (w_h_last && w_v_last) begin
                r_addr_cnt <= '0;
            end else if (w_vis_a) begin
                r_addr_cnt <= r_addr_cnt + AC_W'(1);
            end
            if (w_vis_a) begin
                r_addr <= w_base + ADDR_W'(r_addr_cnt);
            end
            r_vis_b      <= w_vis_a;
            r_hs_b       <= w_hs_a;
            r_vs_b       <= w_vs_a;
            pixel_idx    <= r_vis_b ? rdata : 4'h0;
            VGA_HS       <= r_hs_b;
            VGA_VS       <= r_vs_b;
            VGA_BLANK_N  <= r_vis_b;
            vblank_start <= w_vb_edge;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    logic r_front;
    logic r_ack;

    // The flip lands in vblank, so the new base is first used at address 0 of the next frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_front <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_vb_edge && swap_req;
            if (w_vb_edge && swap_req) begin
                r_front <= ~r_front;
            end
        end
    end

    assign front_sel = r_front;
    assign swap_ack  = r_ack;
`else
    logic w_unused_swap_req;

    assign w_unused_swap_req = swap_req;
    assign front_sel         = 1'b0;
    assign swap_ack          = 1'b0;
`endif

endmodule
